// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, taken-branch flushes and data-memory freezes with timeout.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int LU_STALL    = 1,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ifid_rs_i,
    input  logic [4:0]  ifid_rt_i,
    input  logic        ifid_uses_rt_i,
    input  logic        idex_memread_i,
    input  logic [4:0]  idex_rt_i,
    input  logic        branch_taken_i,
    input  logic        dmem_req_i,
    input  logic        dmem_ack_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        idex_write_o,
    output logic        exmem_write_o,
    output logic        ifid_flush_o,
    output logic        idex_flush_o,
    output logic        exmem_flush_o,
    output logic        err_o
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_MEM_WAIT} state_t;
    typedef enum logic [1:0] {ACT_GO, ACT_FREEZE, ACT_FLUSH, ACT_BUBBLE} act_t;

    localparam logic [2:0] SCNT_LAST  = 3'(LU_STALL - 1);
    localparam logic [7:0] WCNT_LIMIT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [2:0] scnt_q, scnt_d;
    logic [7:0] wcnt_q, wcnt_d;
    logic       susp_q, susp_d;
    logic       err_q, err_d;
    act_t       act;
    logic       hz;
    logic       dmem_stall;

    assign hz = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));
    assign dmem_stall = dmem_req_i & ~dmem_ack_i;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        wcnt_d  = wcnt_q;
        susp_d  = susp_q;
        err_d   = err_q;
        act     = ACT_GO;
        if (!rst_i) begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_stall) begin
                        act     = ACT_FREEZE;
                        state_d = ST_MEM_WAIT;
                        wcnt_d  = 8'd1;
                        susp_d  = 1'b0;
                    end else if (branch_taken_i) begin
                        // The lw that would have caused a hazard is being flushed.
                        act = ACT_FLUSH;
                    end else if (hz) begin
                        act = ACT_BUBBLE;
                        if (LU_STALL > 1) begin
                            state_d = ST_LU_STALL;
                            scnt_d  = 3'd1;
                        end
                    end
                end
                ST_LU_STALL: begin
                    if (dmem_stall) begin
                        // Bubble count is parked; resumes once memory answers.
                        act     = ACT_FREEZE;
                        state_d = ST_MEM_WAIT;
                        wcnt_d  = 8'd1;
                        susp_d  = 1'b1;
                    end else if (branch_taken_i) begin
                        act     = ACT_FLUSH;
                        state_d = ST_RUN;
                        scnt_d  = 3'd0;
                    end else begin
                        act = ACT_BUBBLE;
                        if (scnt_q >= SCNT_LAST) begin
                            state_d = ST_RUN;
                            scnt_d  = 3'd0;
                        end else if (scnt_q != 3'd7) begin
                            scnt_d = scnt_q + 3'd1;
                        end
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ack_i) begin
                        act     = ACT_GO;
                        state_d = susp_q ? ST_LU_STALL : ST_RUN;
                        susp_d  = 1'b0;
                        wcnt_d  = 8'd0;
                    end else if (wcnt_q >= WCNT_LIMIT) begin
                        // Give up on the access and let the pipeline move again.
                        act     = ACT_GO;
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                        susp_d  = 1'b0;
                        scnt_d  = 3'd0;
                        wcnt_d  = 8'd0;
                    end else begin
                        act = ACT_FREEZE;
                        if (wcnt_q != 8'hFF) begin
                            wcnt_d = wcnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_write_o  = 1'b1;
        exmem_write_o = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        case (act)
            ACT_FREEZE: begin
                pc_write_o    = 1'b0;
                ifid_write_o  = 1'b0;
                idex_write_o  = 1'b0;
                exmem_write_o = 1'b0;
            end
            ACT_FLUSH: begin
                ifid_flush_o  = 1'b1;
                idex_flush_o  = 1'b1;
                exmem_flush_o = 1'b1;
            end
            ACT_BUBBLE: begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                idex_flush_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            scnt_q  <= 3'd0;
            wcnt_q  <= 8'd0;
            susp_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            wcnt_q  <= wcnt_d;
            susp_q  <= susp_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ~pc_write_o};
        flush_cnt_d = flush_cnt_q + {31'd0, (act == ACT_FLUSH)};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two configurations driven in lockstep, each against its own reference model.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       memread;
        logic [4:0] idex_rt;
        logic       br;
        logic       req;
        logic       ack;
    } in_t;

    typedef struct {
        in_t        in;
        logic [6:0] exp;
    } vec_t;

    // {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, exmem_f}
    localparam logic [6:0] NORM = 7'b1111000;
    localparam logic [6:0] FRZ  = 7'b0000000;
    localparam logic [6:0] BRF  = 7'b1111111;
    localparam logic [6:0] BUB  = 7'b0011010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, uses_rt_i, memread_i, br_i, req_i, ack_i;
    logic [4:0] rs_i, rt_i, idex_rt_i;

    logic pcw_a, ifw_a, idw_a, exw_a, iff_a, idf_a, exf_a, err_a;
    logic pcw_b, ifw_b, idw_b, exw_b, iff_b, idf_b, exf_b, err_b;
    logic [6:0] out_a, out_b;
    assign out_a = {pcw_a, ifw_a, idw_a, exw_a, iff_a, idf_a, exf_a};
    assign out_b = {pcw_b, ifw_b, idw_b, exw_b, iff_b, idf_b, exf_b};

    pipe_hazard_ctrl #(.LU_STALL(1), .MEM_TIMEOUT(16)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .ifid_rs_i(rs_i), .ifid_rt_i(rt_i),
        .ifid_uses_rt_i(uses_rt_i), .idex_memread_i(memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(br_i), .dmem_req_i(req_i), .dmem_ack_i(ack_i),
        .pc_write_o(pcw_a), .ifid_write_o(ifw_a), .idex_write_o(idw_a), .exmem_write_o(exw_a),
        .ifid_flush_o(iff_a), .idex_flush_o(idf_a), .exmem_flush_o(exf_a), .err_o(err_a)
    );

    pipe_hazard_ctrl #(.LU_STALL(3), .MEM_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .ifid_rs_i(rs_i), .ifid_rt_i(rt_i),
        .ifid_uses_rt_i(uses_rt_i), .idex_memread_i(memread_i), .idex_rt_i(idex_rt_i),
        .branch_taken_i(br_i), .dmem_req_i(req_i), .dmem_ack_i(ack_i),
        .pc_write_o(pcw_b), .ifid_write_o(ifw_b), .idex_write_o(idw_b), .exmem_write_o(exw_b),
        .ifid_flush_o(iff_b), .idex_flush_o(idf_b), .exmem_flush_o(exf_b), .err_o(err_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: bubbles still owed, outstanding memory wait and its age.
    int m_lu[2]   = '{1, 3};
    int m_to[2]   = '{16, 4};
    int m_rem[2]  = '{0, 0};
    int m_held[2] = '{0, 0};
    int m_age[2]  = '{0, 0};
    bit m_wait[2] = '{0, 0};
    bit m_err[2]  = '{0, 0};

    logic [6:0] last_a, last_b;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t x;
        x.rst = 1'b0; x.rs = 5'd0; x.rt = 5'd0; x.uses_rt = 1'b0; x.memread = 1'b0;
        x.idex_rt = 5'd0; x.br = 1'b0; x.req = 1'b0; x.ack = 1'b0;
        return x;
    endfunction

    function automatic in_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic u, logic mr,
                               logic [4:0] irt, logic br, logic rq, logic ak);
        in_t x;
        x.rst = r; x.rs = rs; x.rt = rt; x.uses_rt = u; x.memread = mr;
        x.idex_rt = irt; x.br = br; x.req = rq; x.ack = ak;
        return x;
    endfunction

    task automatic model_step(input int i, input in_t x, output logic [6:0] exp, output logic exp_err);
        bit hz;
        exp_err = m_err[i];
        hz = x.memread && (x.idex_rt != 5'd0) &&
             ((x.idex_rt == x.rs) || (x.uses_rt && (x.idex_rt == x.rt)));
        if (x.rst) begin
            exp = NORM; m_rem[i] = 0; m_wait[i] = 0; m_age[i] = 0; m_held[i] = 0; m_err[i] = 0;
        end else if (m_wait[i]) begin
            if (x.ack) begin
                exp = NORM; m_wait[i] = 0; m_rem[i] = m_held[i];
            end else if (m_age[i] >= m_to[i]) begin
                exp = NORM; m_wait[i] = 0; m_rem[i] = 0; m_err[i] = 1;
            end else begin
                exp = FRZ; m_age[i]++;
            end
        end else if (x.req && !x.ack) begin
            exp = FRZ; m_wait[i] = 1; m_age[i] = 1; m_held[i] = m_rem[i];
        end else if (x.br) begin
            exp = BRF; m_rem[i] = 0;
        end else if (m_rem[i] > 0) begin
            exp = BUB; m_rem[i]--;
        end else if (hz) begin
            exp = BUB; m_rem[i] = m_lu[i] - 1;
        end else begin
            exp = NORM;
        end
    endtask

    task automatic run_cycle(input in_t x);
        logic [6:0] ea, eb;
        logic       erra, errb;
        @(negedge clk);
        rst_i = x.rst; rs_i = x.rs; rt_i = x.rt; uses_rt_i = x.uses_rt; memread_i = x.memread;
        idex_rt_i = x.idex_rt; br_i = x.br; req_i = x.req; ack_i = x.ack;
        #1;
        model_step(0, x, ea, erra);
        model_step(1, x, eb, errb);
        check("ctl_a", {1'b0, out_a}, {1'b0, ea});
        check("err_a", {7'd0, err_a}, {7'd0, erra});
        check("ctl_b", {1'b0, out_b}, {1'b0, eb});
        check("err_b", {7'd0, err_b}, {7'd0, errb});
        last_a = out_a;
        last_b = out_b;
    endtask

    task automatic do_reset();
        in_t x;
        x = idle();
        x.rst = 1'b1;
        run_cycle(x);
    endtask

    vec_t tbl[11];

    initial begin
        in_t x;
        in_t s[7];
        int  n_frz, n_pc0, n_bub;

        rst_i = 1'b1; rs_i = '0; rt_i = '0; uses_rt_i = 1'b0; memread_i = 1'b0;
        idex_rt_i = '0; br_i = 1'b0; req_i = 1'b0; ack_i = 1'b0;
        repeat (2) @(posedge clk);

        // Single-cycle decode vectors for the LU_STALL=1 instance.
        tbl[0]  = '{mk(1, 5'd2, 5'd0, 0, 1, 5'd2, 1, 1, 0), NORM}; // reset forces defaults
        tbl[1]  = '{mk(0, 5'd2, 5'd7, 0, 1, 5'd2, 0, 0, 0), BUB};  // lw $2 then add rs=2
        tbl[2]  = '{mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0), NORM}; // $zero never hazards
        tbl[3]  = '{mk(0, 5'd3, 5'd5, 1, 1, 5'd5, 0, 0, 0), BUB};  // beq reads rt
        tbl[4]  = '{mk(0, 5'd3, 5'd5, 0, 1, 5'd5, 0, 0, 0), NORM}; // rt not read
        tbl[5]  = '{mk(0, 5'd4, 5'd0, 0, 0, 5'd4, 0, 0, 0), NORM}; // not a load
        tbl[6]  = '{mk(0, 5'd2, 5'd0, 0, 1, 5'd2, 1, 0, 0), BRF};  // branch beats hazard
        tbl[7]  = '{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0), NORM}; // next cycle normal
        tbl[8]  = '{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1), NORM}; // zero-wait access
        tbl[9]  = '{mk(0, 5'd6, 5'd0, 0, 1, 5'd6, 0, 1, 1), BUB};  // zero-wait with hazard
        tbl[10] = '{mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0), FRZ};  // wait state starts
        for (int k = 0; k < 11; k++) begin
            run_cycle(tbl[k].in);
            check("tbl_vec", {1'b0, last_a}, {1'b0, tbl[k].exp});
        end

        // Memory ack after three wait cycles.
        do_reset();
        n_frz = 0;
        x = idle(); x.req = 1'b1;
        repeat (3) begin
            run_cycle(x);
            if (last_a == FRZ) n_frz++;
        end
        x.ack = 1'b1;
        run_cycle(x);
        check("t4_ack_cycle", {1'b0, last_a}, {1'b0, NORM});
        check("t4_frozen", 8'(n_frz), 8'd3);
        run_cycle(idle());
        check("t4_err", {7'd0, err_a}, 8'd0);

        // Timeout with MEM_TIMEOUT=4.
        do_reset();
        n_frz = 0;
        x = idle(); x.req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            run_cycle(x);
            if (last_b == FRZ) n_frz++;
        end
        check("t5_frozen_b", 8'(n_frz), 8'd4);
        check("t5_release_b", {1'b0, last_b}, {1'b0, NORM});
        repeat (3) run_cycle(idle());
        check("t5_err_b", {7'd0, err_b}, 8'd1);
        run_cycle(mk(0, 5'd2, 5'd0, 0, 1, 5'd2, 0, 0, 0));
        check("t5_run_b", {1'b0, last_b}, {1'b0, BUB});
        do_reset();
        run_cycle(idle());
        check("t5_err_clr", {7'd0, err_b}, 8'd0);

        // LU_STALL=3 with a two-cycle memory wait in the second bubble.
        do_reset();
        s[0] = mk(0, 5'd2, 5'd0, 0, 1, 5'd2, 0, 0, 0);
        s[1] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0);
        s[2] = s[1];
        s[3] = mk(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
        s[4] = idle(); s[5] = idle(); s[6] = idle();
        n_pc0 = 0; n_bub = 0; n_frz = 0;
        for (int k = 0; k < 7; k++) begin
            run_cycle(s[k]);
            if (!last_b[6]) n_pc0++;
            if (last_b[1]) n_bub++;
            if (last_b == FRZ) n_frz++;
        end
        check("t6_pc_hold", 8'(n_pc0), 8'd5);
        check("t6_bubbles", 8'(n_bub), 8'd3);
        check("t6_frozen", 8'(n_frz), 8'd2);

        // Reset in the middle of a load-use stall.
        do_reset();
        run_cycle(s[0]);
        x = s[0]; x.rst = 1'b1;
        run_cycle(x);
        check("rst_mid_b", {1'b0, last_b}, {1'b0, NORM});
        run_cycle(idle());
        check("rst_after_b", {1'b0, last_b}, {1'b0, NORM});

        // Randomized traffic with a varying memory ack rate.
        for (int seg = 0; seg < 6; seg++) begin
            repeat (500) begin
                x.rst     = ($urandom_range(0, 63) == 0);
                x.rs      = 5'($urandom_range(0, 3));
                x.rt      = 5'($urandom_range(0, 3));
                x.idex_rt = 5'($urandom_range(0, 3));
                x.uses_rt = 1'($urandom_range(0, 1));
                x.memread = 1'($urandom_range(0, 1));
                x.br      = ($urandom_range(0, 5) == 0);
                x.req     = ($urandom_range(0, 2) == 0);
                x.ack     = ($urandom_range(0, 7) <= seg);
                run_cycle(x);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
